// File: rtl/pipe_skid_stage.sv
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : Inter-stage pipeline register with valid/ready handshake,
//             global memory-ready stall, synchronous flush and a one-entry
//             skid slot. in_ready depends only on a register bit.
//  Option   : PIPE_STALL_CNT_EN adds a saturating stall counter (stall_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int DATA_W = 71,
    parameter int NREADY = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NREADY-1:0] mem_ready,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occ
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // State bits are {skid_valid, main_valid}; 2'b10 must never occur.
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b01;
    localparam logic [1:0] c_TWO   = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic w_advance;
    logic w_up_xfer;
    logic w_dn_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_advance = &mem_ready;
    assign w_up_xfer = in_valid & ~r_state[1] & w_advance;
    assign w_dn_xfer = r_state[0] & out_ready & w_advance;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_up_xfer) begin
                        w_state_nxt    = c_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                c_ONE: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_up_xfer) begin
                        w_state_nxt = c_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_dn_xfer) begin
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_TWO: begin
                    if (w_dn_xfer) begin
                        w_state_nxt      = c_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = ~r_state[1];
        out_valid = r_state[0];
        out_data  = r_main_data;
        occ       = {1'b0, r_state[0]} + {1'b0, r_state[1]};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Counts both backpressure and memory-freeze cycles while data is held.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (r_state[0] && !w_dn_xfer && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    a_no_orphan_skid : assert property (@(posedge clock) disable iff (!resetn)
        r_state != 2'b10);

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, skid fill/drain, memory
// freeze, flush under stall, asynchronous reset and (optionally) stall count.
`default_nettype none

module tb_pipe_skid_stage;

    localparam int DATA_W = 71;
    localparam int NREADY = 2;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NREADY-1:0] mem_ready;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occ;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0]       stall_cnt;
    logic              s_in_ready;
    logic              s_out_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occ;
    logic [2:0]        s_stall_cnt;
`endif

    pipe_skid_stage #(.DATA_W(DATA_W), .NREADY(NREADY), .CNT_W(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mem_ready (mem_ready),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occ       (occ)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef PIPE_STALL_CNT_EN
    pipe_skid_stage #(.DATA_W(DATA_W), .NREADY(NREADY), .CNT_W(3)) dut_small (
        .clock     (clock),
        .resetn    (resetn),
        .mem_ready (mem_ready),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (out_ready),
        .occ       (s_occ),
        .stall_cnt (s_stall_cnt)
    );
`endif

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic r,
                               input logic [1:0] o, input logic [DATA_W-1:0] d);
        check_eq({tag, ".out_valid"}, 72'(out_valid), 72'(v));
        check_eq({tag, ".in_ready"},  72'(in_ready),  72'(r));
        check_eq({tag, ".occ"},       72'(occ),       72'(o));
        if (v) check_eq({tag, ".out_data"}, 72'(out_data), 72'(d));
    endtask

    initial begin
        resetn    = 1'b0;
        mem_ready = 2'b11;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check_state("reset", 1'b0, 1'b1, 2'd0, '0);
        check_eq("reset.out_data", 72'(out_data), 72'h0);
        resetn = 1'b1;
        tick();

        // Streaming at full throughput
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DATA_W'(i);
            tick();
            check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, DATA_W'(i));
        end
        in_valid = 1'b0;
        tick();
        check_state("stream_drain", 1'b0, 1'b1, 2'd0, '0);

        // Skid fill then ordered drain
        in_valid = 1'b1; in_data = 'hA;
        tick();
        check_state("skid_a", 1'b1, 1'b1, 2'd1, 'hA);
        out_ready = 1'b0; in_data = 'hB;
        tick();
        check_state("skid_full", 1'b1, 1'b0, 2'd2, 'hA);
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        check_state("skid_b", 1'b1, 1'b1, 2'd1, 'hB);
        tick();
        check_state("skid_empty", 1'b0, 1'b1, 2'd0, '0);

        // Memory freeze: nothing moves while advance is low
        in_valid = 1'b1; in_data = 'hC;
        tick();
        mem_ready = 2'b01; in_data = 'hD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("freeze%0d", i), 1'b1, 1'b1, 2'd1, 'hC);
        end
        mem_ready = 2'b11;
        tick();
        check_state("resume", 1'b1, 1'b1, 2'd1, 'hD);
        in_valid = 1'b0;
        tick();
        check_state("resume_drain", 1'b0, 1'b1, 2'd0, '0);

        // Flush wins over a stalled, full stage
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h5;
        tick();
        in_data = 'h6;
        tick();
        check_state("pre_flush", 1'b1, 1'b0, 2'd2, 'h5);
        flush = 1'b1; mem_ready = 2'b00;
        tick();
        check_state("flush", 1'b0, 1'b1, 2'd0, '0);
        flush = 1'b0; mem_ready = 2'b11;

        // Asynchronous reset mid-cycle while full
        in_data = 'h7;
        tick();
        in_data = 'h8;
        tick();
        check_state("pre_reset", 1'b1, 1'b0, 2'd2, 'h7);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_state("async_reset", 1'b0, 1'b1, 2'd0, '0);
        check_eq("async_reset.out_data", 72'(out_data), 72'h0);
        #1;
        resetn = 1'b1;

`ifdef PIPE_STALL_CNT_EN
        check_eq("stall_cnt.reset", 72'(stall_cnt), 72'h0);
        in_valid = 1'b1; in_data = 'h9; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("stall_cnt.five", 72'(stall_cnt), 72'd5);
        for (int i = 0; i < 5; i++) tick();
        check_eq("stall_cnt.ten", 72'(stall_cnt), 72'd10);
        check_eq("stall_cnt.sat", 72'(s_stall_cnt), 72'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("stall_cnt.flush_keeps", 72'(stall_cnt), 72'd11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register, for use at any inter-stage boundary of the cached pipeline (IF/ID through MEM/WB).
- Carries an opaque DATA_W-bit payload between stages with a valid/ready handshake and a global stall qualifier formed from NREADY memory-ready inputs.
- Adds a synchronous flush and a one-entry skid slot, so upstream ready is a registered signal and never combinationally depends on downstream ready.

Parameters:
- DATA_W, 71, payload width; default packs wreg, m2reg, mo[31:0], alu[31:0] and rn[4:0] as 1+1+32+32+5.
- NREADY, 2, number of memory-ready qualifiers ANDed into the global advance signal (imem, dmem).
- CNT_W, 32, stall counter width; used only when the optional feature is compiled in.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- mem_ready  in  NREADY  per-memory ready; advance = &mem_ready
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream payload valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  registered; equals ~skid_valid
- out_valid  out  1  main entry valid
- out_data  out  DATA_W  main entry payload
- out_ready  in  1  downstream accepts
- occ  out  2  occupancy 0/1/2
- stall_cnt  out  CNT_W  stall cycle count; present only with PIPE_STALL_CNT_EN

Behaviour:
- Reset: asynchronous, active-low. Clears main_valid, skid_valid, main_data and skid_data to 0. Gives out_valid=0, in_ready=1, occ=0, out_data=0, stall_cnt=0.
- Transfer conditions:
  - up_xfer = in_valid & in_ready & advance
  - dn_xfer = out_valid & out_ready & advance
- advance=0: no state or data changes, and no transfer is counted on either side. Payload held stable, matching the current pipeline freeze.
- Occupancy states and transitions:
  - EMPTY: up_xfer -> ONE with main<=in_data. Otherwise stay in EMPTY.
  - ONE:
    - up_xfer & dn_xfer -> ONE, main<=in_data.
    - up_xfer only -> TWO, skid<=in_data.
    - dn_xfer only -> EMPTY.
    - Neither -> hold.
  - TWO: in_ready=0, so up_xfer is impossible. dn_xfer -> ONE with main<=skid. Otherwise hold.
- Latency: 1 cycle from up_xfer to out_valid when the stage is empty. Throughput is 1 transfer per advancing cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is always younger than the main entry.
- Flush:
  - Highest priority. Takes effect on the next edge, giving EMPTY with both valid bits cleared.
  - Applies even when advance=0. A coincident up_xfer is discarded. Data registers may keep stale values; consumers qualify with out_valid.
- Reset mid-operation: immediate return to reset values. No partial transfer survives.
- Invalid payloads never propagate: out_valid=0 implies downstream must ignore out_data.
- occ = main_valid + skid_valid. The state skid_valid=1 with main_valid=0 is unreachable; assert on it in simulation.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists. Increments by 1 each cycle where out_valid=1 and dn_xfer=0, i.e. a backpressure or memory stall.
  - Saturates at all-ones. Clears on reset and does not clear on flush.
- Undefined: the port, the counter and its logic are omitted entirely. Core behaviour is identical.

Test Plan:
- Reset, then mem_ready=2'b11, out_ready=1, stream in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occ stays at 1; in_ready stays 1.
- With occ=1 (holding 0xA), drop out_ready for one cycle while sending 0xB -> occ=2, in_ready=0. Raise out_ready -> out sequence 0xA, then 0xB, with no loss or duplication.
- mem_ready=2'b01 for 3 cycles with in_valid=1 and out_ready=1 -> no state change, out_data frozen, in_data not captured. Restore 2'b11 -> resumes.
- occ=2, assert flush together with mem_ready=2'b00 -> next cycle occ=0, out_valid=0, in_ready=1.
- Deassert resetn asynchronously mid-cycle with occ=2 -> outputs reach reset values before the next clock edge.
- With PIPE_STALL_CNT_EN: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5. Then run with CNT_W=3 for 10 stall cycles -> stall_cnt saturates at 7.
